// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
// A queued write is a destination register plus its result data.
package regfile_pkg;

  localparam int DATAWIDTH  = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATAWIDTH-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the write-back queue's producer, regfile write and hazard-lookup signals.
// The slave modport is the queue's view of the bundle; the master modport is its environment's view.
interface regfile_wb_queue_if #(
  parameter int DATAWIDTH = regfile_pkg::DATAWIDTH,
  parameter int DEPTH     = 4
);

  localparam int AW = regfile_pkg::REG_ADDR_W;

  logic                     alu_valid;
  logic                     alu_ready;
  logic [AW-1:0]            alu_rd;
  logic [DATAWIDTH-1:0]     alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [AW-1:0]            mem_rd;
  logic [DATAWIDTH-1:0]     mem_data;
  logic                     wr_grant;
  logic                     write;
  logic [AW-1:0]            writeReg;
  logic [DATAWIDTH-1:0]     writeData;
  logic [AW-1:0]            query_reg1;
  logic [AW-1:0]            query_reg2;
  logic                     pending1;
  logic                     pending2;
  logic [DATAWIDTH-1:0]     fwd_data1;
  logic [DATAWIDTH-1:0]     fwd_data2;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  wr_grant, query_reg1, query_reg2,
    output alu_ready, mem_ready, write, writeReg, writeData,
    output pending1, pending2, fwd_data1, fwd_data2, count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output wr_grant, query_reg1, query_reg2,
    input  alu_ready, mem_ready, write, writeReg, writeData,
    input  pending1, pending2, fwd_data1, fwd_data2, count
  );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Circular buffer of pending regfile writes.
// Every slot is exposed with its valid bit so the top can search the queue for hazards.
module regfile_wb_fifo import regfile_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] head,
  output wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         valids
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // The caller never pushes when full or pops when empty.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q]   <= push_entry;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  assign count   = count_q;
  assign head    = head_q;
  assign entries = mem_q;
  assign valids  = valid_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue: arbitrates ALU/load results into an in-order queue, drains it into the
// regfile write port and answers decode's pending-write / forwarding lookups.
module regfile_wb_queue #(
  parameter int DATAWIDTH = regfile_pkg::DATAWIDTH,
  parameter int DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_queue_if.slave  bus
);

  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t            entries [DEPTH];
  logic [DEPTH-1:0]     valids;
  logic [PTR_W-1:0]     head;
  logic [PTR_W:0]       count;
  wb_entry_t            head_entry;
  wb_entry_t            push_entry;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 pend1;
  logic                 pend2;
  logic [DATAWIDTH-1:0] fwd1;
  logic [DATAWIDTH-1:0] fwd2;
  logic [PTR_W-1:0]     idx;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .entries    (entries),
    .valids     (valids)
  );

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Readies look only at current occupancy, never at a same-cycle drain; loads win over ALU.
  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;

  // Writes to x0 complete the handshake but are dropped rather than queued.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (bus.mem_valid && !full) begin
      push_entry = '{rd: bus.mem_rd, data: bus.mem_data};
      push       = (bus.mem_rd != '0);
    end else if (bus.alu_valid && !full) begin
      push_entry = '{rd: bus.alu_rd, data: bus.alu_data};
      push       = (bus.alu_rd != '0);
    end
  end

  assign head_entry    = entries[head];
  assign pop           = !empty && bus.wr_grant;
  assign bus.write     = pop;
  assign bus.writeReg  = head_entry.rd;
  assign bus.writeData = head_entry.data;
  assign bus.count     = count;

  // Walk from oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    fwd1  = '0;
    fwd2  = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valids[idx] && bus.query_reg1 != '0 && entries[idx].rd == bus.query_reg1) begin
        pend1 = 1'b1;
        fwd1  = entries[idx].data;
      end
      if (valids[idx] && bus.query_reg2 != '0 && entries[idx].rd == bus.query_reg2) begin
        pend2 = 1'b1;
        fwd2  = entries[idx].data;
      end
    end
  end

  assign bus.pending1  = pend1;
  assign bus.pending2  = pend2;
  assign bus.fwd_data1 = fwd1;
  assign bus.fwd_data2 = fwd2;

endmodule
